// File: rtl/axi_lite_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// Contents:
//   state_e      - controller state encoding
//   RESP_*       - AXI BRESP/RRESP codes
//   wdog_width() - bit width of a watchdog counter that must reach a given cycle limit
package axi_lite_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StRsp,
        StHalt
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A limit of 0 (watchdog disabled) still needs a legal 1-bit counter.
    function automatic int unsigned wdog_width(input int unsigned timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/axi_lite_master_cmd.sv
// AXI4-Lite initiator driven by a single-outstanding command/response interface.
// Ports:
//   axi_clk, axi_reset             - clock, asynchronous active-high reset
//   cmd_valid/ready, cmd_wr,
//   cmd_addr/wdata/wstrb           - command request (write when cmd_wr = 1)
//   rsp_valid/ready, rsp_rdata,
//   rsp_resp                       - response (rdata is 0 for writes)
//   rsp_timeout                    - sticky watchdog flag; block halted until reset
//   wr_count, rd_count             - completed transaction counters (wrap at 16 bits)
//   m00_axi_*                      - AXI4-Lite master channels
module axi_lite_master_cmd
    import axi_lite_master_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 8,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
    input  logic                            axi_clk,
    input  logic                            axi_reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [15:0]                     wr_count,
    output logic [15:0]                     rd_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                      m00_axi_awprot,
    output logic                            m00_axi_awvalid,
    input  logic                            m00_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                            m00_axi_wvalid,
    input  logic                            m00_axi_wready,
    input  logic [1:0]                      m00_axi_bresp,
    input  logic                            m00_axi_bvalid,
    output logic                            m00_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                      m00_axi_arprot,
    output logic                            m00_axi_arvalid,
    input  logic                            m00_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                      m00_axi_rresp,
    input  logic                            m00_axi_rvalid,
    output logic                            m00_axi_rready
);

    localparam int unsigned       StrbW     = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned       WdogW     = wdog_width(TIMEOUT_CYCLES);
    localparam logic [WdogW-1:0]  WdogLimit = WdogW'(TIMEOUT_CYCLES);
    localparam bit                WdogOn    = (TIMEOUT_CYCLES != 0);

    state_e                          state_q, state_d;
    logic                            live_q;
    logic                            latch_cmd;
    logic                            busy;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [StrbW-1:0]                wstrb_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                      resp_q, resp_d;
    logic [15:0]                     wr_count_q, wr_count_d;
    logic [15:0]                     rd_count_q, rd_count_d;
    logic [WdogW-1:0]                wdog_q, wdog_d;

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q    <= StIdle;
            live_q     <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            resp_q     <= RESP_OKAY;
            wr_count_q <= '0;
            rd_count_q <= '0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            // Holds cmd_ready low until the first edge after reset release.
            live_q     <= 1'b1;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
            wdog_q     <= wdog_d;
            if (latch_cmd) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        aw_done_d       = aw_done_q;
        w_done_d        = w_done_q;
        rdata_d         = rdata_q;
        resp_d          = resp_q;
        wr_count_d      = wr_count_q;
        rd_count_d      = rd_count_q;
        wdog_d          = wdog_q;
        latch_cmd       = 1'b0;
        busy            = 1'b0;
        cmd_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_timeout     = 1'b0;
        m00_axi_awvalid = 1'b0;
        m00_axi_wvalid  = 1'b0;
        m00_axi_bready  = 1'b0;
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = live_q;
                if (cmd_valid && live_q) begin
                    latch_cmd = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wdog_d    = '0;
                    state_d   = cmd_wr ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                busy            = 1'b1;
                m00_axi_awvalid = !aw_done_q;
                m00_axi_wvalid  = !w_done_q;
                if (m00_axi_awvalid && m00_axi_awready) aw_done_d = 1'b1;
                if (m00_axi_wvalid && m00_axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = StWrResp;
            end
            StWrResp: begin
                busy           = 1'b1;
                m00_axi_bready = 1'b1;
                if (m00_axi_bvalid) begin
                    resp_d     = m00_axi_bresp;
                    rdata_d    = '0;
                    wr_count_d = wr_count_q + 16'd1;
                    state_d    = StRsp;
                end
            end
            StRdReq: begin
                busy            = 1'b1;
                m00_axi_arvalid = 1'b1;
                if (m00_axi_arready) state_d = StRdResp;
            end
            StRdResp: begin
                busy           = 1'b1;
                m00_axi_rready = 1'b1;
                if (m00_axi_rvalid) begin
                    resp_d     = m00_axi_rresp;
                    rdata_d    = m00_axi_rdata;
                    rd_count_d = rd_count_q + 16'd1;
                    state_d    = StRsp;
                end
            end
            StRsp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = StIdle;
            end
            StHalt: begin
                rsp_timeout = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // A response completing on the limit cycle wins over the abort.
        if (busy && WdogOn) begin
            wdog_d = wdog_q + WdogW'(1);
            if (wdog_d == WdogLimit && state_d != StRsp) state_d = StHalt;
        end
    end

    assign rsp_rdata      = rdata_q;
    assign rsp_resp       = resp_q;
    assign wr_count       = wr_count_q;
    assign rd_count       = rd_count_q;
    assign m00_axi_awaddr = addr_q;
    assign m00_axi_araddr = addr_q;
    assign m00_axi_wdata  = wdata_q;
    assign m00_axi_wstrb  = wstrb_q;
    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;

endmodule

// File: doc/axi_lite_master_cmd.md
Name: axi_lite_master_cmd

Overview:
- AXI4-Lite initiator that turns a simple single-outstanding command/response interface into AXI4-Lite read and write transactions.
- It is the bus-side counterpart of the codec register slave. It lets on-chip logic, test sequencers and bring-up controllers program the codec/sampler register file without the PS.
- It sits in the AXI clock domain.
- It supports one transaction in flight, with a per-transaction timeout watchdog.

Parameters:
- C_M_AXI_ADDR_WIDTH, 8, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- TIMEOUT_CYCLES, 1024, bus cycles allowed per transaction before abort; 0 disables the watchdog.

Ports:
- axi_clk  in  1  AXI clock; the only clock.
- axi_reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as received.
- rsp_timeout  out  1  watchdog fired; block is halted.
- wr_count  out  16  completed writes, wraps at 0xFFFF->0.
- rd_count  out  16  completed reads, wraps at 0xFFFF->0.
- m00_axi_aw*/w*/b*/ar*/r*  standard AXI4-Lite master channel signals at ADDR_W/DATA_W widths; awprot = arprot = 3'b000.

Behaviour:
- Reset: all outputs 0, except cmd_ready, which is also 0 during reset. All VALID/READY lines 0, counters 0, state IDLE. cmd_ready rises the first cycle after reset deasserts.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP, HALT.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch addr/wdata/wstrb/wr and drop cmd_ready.
  - Go to WR_REQ if cmd_wr, else RD_REQ.
- WR_REQ:
  - awvalid and wvalid assert in the cycle after acceptance.
  - Each deasserts independently on its own handshake; the order of AW and W is free.
  - Exit to WR_RESP once both handshakes are done. Handshakes completing in the same cycle exit in one cycle.
- WR_RESP:
  - bready = 1.
  - On bvalid: capture bresp, increment wr_count, go to RSP.
- RD_REQ:
  - arvalid = 1 until arready, then go to RD_RESP.
- RD_RESP:
  - rready = 1.
  - On rvalid: capture rdata/rresp, increment rd_count, go to RSP.
- RSP:
  - rsp_valid = 1, held stable until rsp_ready.
  - On handshake go to IDLE; cmd_ready = 1 the next cycle.
  - Minimum command-to-response latency is 3 cycles: accept, address/data handshake, response handshake.
- SLVERR/DECERR are reported through rsp_resp only; the counters still increment.
- Watchdog:
  - The counter clears on command acceptance and counts every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - On reaching TIMEOUT_CYCLES: all AXI VALID/READY lines drop, and rsp_timeout = 1, sticky.
  - Enter HALT with cmd_ready = 0 and rsp_valid = 0. Only reset exits HALT.
  - The watchdog is frozen in RSP; a slow consumer is not a fault.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). The latched command is discarded and no response is issued.
- Write data and strobes are driven from the latched copies, so the command inputs may change after acceptance.

Decomposition:
- Package axi_lite_master_pkg:
  - State enum.
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - Watchdog counter width, computed as clog2(TIMEOUT_CYCLES+1).
- No sub-module. The watchdog is a counter inside the FSM module.

Test Plan:
- Write 0xDEADBEEF to 0x08 with strobe 0xF. Slave readies are high immediately and bresp = OKAY. Required: awaddr = 0x08 and wdata = 0xDEADBEEF seen; rsp_valid 3 cycles after acceptance with rsp_resp = 0; wr_count = 1.
- Write where wready is asserted 4 cycles before awready. Required: wvalid drops after the W handshake, awvalid is held until its handshake, and exactly one B is consumed.
- Read of 0x10 with arready delayed 2 cycles and rvalid returning 0x12345678 after 3 more cycles. Required: rsp_rdata = 0x12345678, rd_count = 1. rsp_valid is held for 5 cycles with rsp_ready = 0, then clears on the handshake.
- Read answered with rresp = 2'b10. Required: rsp_resp = 2'b10 and rd_count increments.
- TIMEOUT_CYCLES = 16 with a slave that never asserts bvalid. Required: rsp_timeout = 1 at cycle 16, bready = 0, cmd_ready stays 0 until reset.
- axi_reset pulsed while arvalid = 1. Required: arvalid drops asynchronously, no rsp_valid, counters = 0, and cmd_ready = 1 one cycle after release.
